// File: rtl/video_write_scheduler.sv
// Write-port scheduler for text-mode video memory: shares one masked write port
// between a CPU single-cell stream and a raster rectangle-fill engine.
`ifndef TEXTCOLS_CHAR
`define TEXTCOLS_CHAR 80
`endif
`ifndef TEXTROWS_CHAR
`define TEXTROWS_CHAR 30
`endif
`ifndef TEXTCOLS_RANGE
`define TEXTCOLS_RANGE 6:0
`endif
`ifndef TEXTROWS_RANGE
`define TEXTROWS_RANGE 4:0
`endif
`ifndef CHARATTR_RANGE
`define CHARATTR_RANGE 23:0
`endif

module video_write_scheduler #(
    parameter int COLS = `TEXTCOLS_CHAR,
    parameter int ROWS = `TEXTROWS_CHAR
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_valid,
    output logic                    cpu_ready,
    input  logic [15:0]             cpu_address,
    input  logic [`CHARATTR_RANGE]  cpu_value,
    input  logic [`CHARATTR_RANGE]  cpu_mask,
    input  logic                    fill_start,
    input  logic [`TEXTCOLS_RANGE]  fill_x0,
    input  logic [`TEXTCOLS_RANGE]  fill_x1,
    input  logic [`TEXTROWS_RANGE]  fill_y0,
    input  logic [`TEXTROWS_RANGE]  fill_y1,
    input  logic [`CHARATTR_RANGE]  fill_value,
    input  logic [`CHARATTR_RANGE]  fill_mask,
    output logic                    fill_busy,
    output logic                    fill_done,
    output logic                    fill_error,
    output logic                    video_write,
    output logic [15:0]             video_address,
    output logic [`CHARATTR_RANGE]  video_value,
    output logic [`CHARATTR_RANGE]  video_mask
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                   state, state_n;
    logic [`TEXTCOLS_RANGE]   x, x0, x1;
    logic [`TEXTROWS_RANGE]   y, y1;
    logic [15:0]              row_base, y0_base;
    logic [`CHARATTR_RANGE]   fval, fmask;
    logic                     last_fill;
    logic                     grant_cpu, grant_fill, accept, reject, at_last, bad_cmd;

    // y0*COLS as a shift/add sum over the set bits of y0, ready on the accept edge
    always_comb begin
        y0_base = '0;
        for (int i = 0; i < $bits(fill_y0); i++)
            if (fill_y0[i]) y0_base = y0_base + 16'(COLS << i);
    end

    assign bad_cmd   = (fill_x0 > fill_x1) || (fill_y0 > fill_y1) ||
                       (int'(fill_x1) >= COLS) || (int'(fill_y1) >= ROWS);
    assign at_last   = (x == x1) && (y == y1);
    assign fill_busy = (state == FILL);
    assign cpu_ready = (state == IDLE) || last_fill;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        grant_cpu  = 1'b0;
        grant_fill = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                grant_cpu = cpu_valid;
                if (fill_start) begin
                    if (bad_cmd) reject = 1'b1;
                    else begin
                        accept  = 1'b1;
                        state_n = FILL;
                    end
                end
            end
            FILL: begin
                if (cpu_valid && last_fill) grant_cpu = 1'b1;
                else begin
                    grant_fill = 1'b1;
                    if (at_last) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            video_write   <= 1'b0;
            video_address <= '0;
            video_value   <= '0;
            video_mask    <= '0;
            fill_done     <= 1'b0;
            fill_error    <= 1'b0;
            last_fill     <= 1'b0;
            x             <= '0;
            x0            <= '0;
            x1            <= '0;
            y             <= '0;
            y1            <= '0;
            row_base      <= '0;
            fval          <= '0;
            fmask         <= '0;
        end else begin
            video_write <= grant_cpu || grant_fill;
            fill_done   <= grant_fill && at_last;
            fill_error  <= reject;
            if (grant_cpu) begin
                video_address <= cpu_address;
                video_value   <= cpu_value;
                video_mask    <= cpu_mask;
                last_fill     <= 1'b0;
            end else if (grant_fill) begin
                video_address <= row_base + 16'(x);
                video_value   <= fval;
                video_mask    <= fmask;
                last_fill     <= 1'b1;
                if (x == x1) begin
                    x        <= x0;
                    y        <= y + 1'b1;
                    row_base <= row_base + 16'(COLS);
                end else begin
                    x <= x + 1'b1;
                end
            end
            // accept only happens in IDLE, so it never collides with a fill grant
            if (accept) begin
                x         <= fill_x0;
                x0        <= fill_x0;
                x1        <= fill_x1;
                y         <= fill_y0;
                y1        <= fill_y1;
                row_base  <= y0_base;
                fval      <= fill_value;
                fmask     <= fill_mask;
                last_fill <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_video_write_scheduler.sv
// Bench for video_write_scheduler: queue-based reference model checked every cycle,
// directed scenarios pinned with literal address sequences, then random traffic.
module tb_video_write_scheduler;

    localparam int COLS = 8;
    localparam int ROWS = 4;

    logic        clk, reset;
    logic        cpu_valid, cpu_ready;
    logic [15:0] cpu_address;
    logic [23:0] cpu_value, cpu_mask;
    logic        fill_start;
    logic [6:0]  fill_x0, fill_x1;
    logic [4:0]  fill_y0, fill_y1;
    logic [23:0] fill_value, fill_mask;
    logic        fill_busy, fill_done, fill_error;
    logic        video_write;
    logic [15:0] video_address;
    logic [23:0] video_value, video_mask;

    video_write_scheduler #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_address(cpu_address),
        .cpu_value(cpu_value), .cpu_mask(cpu_mask),
        .fill_start(fill_start), .fill_x0(fill_x0), .fill_x1(fill_x1),
        .fill_y0(fill_y0), .fill_y1(fill_y1), .fill_value(fill_value), .fill_mask(fill_mask),
        .fill_busy(fill_busy), .fill_done(fill_done), .fill_error(fill_error),
        .video_write(video_write), .video_address(video_address),
        .video_value(video_value), .video_mask(video_mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: pending fill cells as an address queue
    logic [15:0] cells[$];
    logic        m_write, m_done, m_err, m_last;
    logic [15:0] m_addr;
    logic [23:0] m_val, m_mask, m_fval, m_fmask;
    logic        m_idle;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_write = 0; m_done = 0; m_err = 0; m_last = 0;
            m_addr = 0; m_val = 0; m_mask = 0;
            cells.delete();
        end else begin
            m_idle = (cells.size() == 0);
            m_write = 0; m_done = 0; m_err = 0;
            if (m_idle) begin
                if (cpu_valid) begin
                    m_write = 1; m_addr = cpu_address; m_val = cpu_value; m_mask = cpu_mask;
                end
                if (fill_start) begin
                    if (fill_x0 > fill_x1 || fill_y0 > fill_y1 ||
                        int'(fill_x1) >= COLS || int'(fill_y1) >= ROWS)
                        m_err = 1;
                    else begin
                        for (int yy = int'(fill_y0); yy <= int'(fill_y1); yy++)
                            for (int xx = int'(fill_x0); xx <= int'(fill_x1); xx++)
                                cells.push_back(16'(yy * COLS + xx));
                        m_fval = fill_value; m_fmask = fill_mask; m_last = 0;
                    end
                end
            end else if (cpu_valid && m_last) begin
                m_write = 1; m_addr = cpu_address; m_val = cpu_value; m_mask = cpu_mask;
                m_last = 0;
            end else begin
                m_write = 1; m_addr = cells.pop_front(); m_val = m_fval; m_mask = m_fmask;
                m_last = 1;
                if (cells.size() == 0) m_done = 1;
            end
        end
    end

    logic [15:0] dut_log[$];
    logic [15:0] mdl_log[$];
    int          done_cnt, err_cnt;
    logic        busy_seen;
    logic [15:0] done_addr;
    logic [23:0] last_val, last_mask;

    always @(negedge clk) begin
        chk("video_write", 32'(video_write), 32'(m_write));
        chk("video_address", 32'(video_address), 32'(m_addr));
        chk("video_value", 32'(video_value), 32'(m_val));
        chk("video_mask", 32'(video_mask), 32'(m_mask));
        chk("fill_busy", 32'(fill_busy), 32'(cells.size() != 0));
        chk("fill_done", 32'(fill_done), 32'(m_done));
        chk("fill_error", 32'(fill_error), 32'(m_err));
        chk("cpu_ready", 32'(cpu_ready), 32'((cells.size() == 0) || m_last));
        if (video_write) begin
            dut_log.push_back(video_address);
            last_val = video_value; last_mask = video_mask;
        end
        if (m_write) mdl_log.push_back(m_addr);
        if (fill_done) begin done_cnt++; done_addr = video_address; end
        if (fill_error) err_cnt++;
        if (fill_busy) busy_seen = 1;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        dut_log.delete(); mdl_log.delete();
        done_cnt = 0; err_cnt = 0; busy_seen = 0;
    endtask

    // compares the first exp.size() logged addresses of DUT and model against literals
    task automatic check_log(input string name, input logic [15:0] exp[$], input bit exact);
        if (exact) begin
            chk({name, "_dut_len"}, 32'(dut_log.size()), 32'(exp.size()));
            chk({name, "_mdl_len"}, 32'(mdl_log.size()), 32'(exp.size()));
        end
        for (int i = 0; i < exp.size(); i++) begin
            chk({name, "_dut"}, (i < dut_log.size()) ? 32'(dut_log[i]) : 32'hDEAD_BEEF, 32'(exp[i]));
            chk({name, "_mdl"}, (i < mdl_log.size()) ? 32'(mdl_log[i]) : 32'hDEAD_BEEF, 32'(exp[i]));
        end
    endtask

    task automatic start_fill(input int x0, input int x1, input int y0, input int y1);
        fill_x0 = 7'(x0); fill_x1 = 7'(x1); fill_y0 = 5'(y0); fill_y1 = 5'(y1);
        fill_start = 1;
        cyc();
        fill_start = 0;
    endtask

    logic [15:0] exp_q[$];

    initial begin
        reset = 0; cpu_valid = 0; cpu_address = 0; cpu_value = 0; cpu_mask = 0;
        fill_start = 0; fill_x0 = 0; fill_x1 = 0; fill_y0 = 0; fill_y1 = 0;
        fill_value = 24'hABCDEF; fill_mask = 24'h00FF00;
        clear_logs();
        repeat (3) cyc();
        chk("rst_write", 32'(video_write), 0);
        chk("rst_addr", 32'(video_address), 0);
        chk("rst_busy", 32'(fill_busy), 0);
        chk("rst_ready", 32'(cpu_ready), 1);
        reset = 1;
        cyc();

        // single CPU write
        clear_logs();
        cpu_valid = 1; cpu_address = 16'd5; cpu_value = 24'h123456; cpu_mask = 24'hFFFFFF;
        cyc();
        cpu_valid = 0;
        repeat (3) cyc();
        exp_q = {16'd5};
        check_log("cpu1", exp_q, 1);
        chk("cpu1_val", 32'(last_val), 32'h123456);
        chk("cpu1_mask", 32'(last_mask), 32'hFFFFFF);

        // fill (2,1)-(4,2), CPU idle
        clear_logs();
        start_fill(2, 4, 1, 2);
        repeat (10) cyc();
        exp_q = {16'd10, 16'd11, 16'd12, 16'd18, 16'd19, 16'd20};
        check_log("fill_idle", exp_q, 1);
        chk("fill_idle_done_cnt", 32'(done_cnt), 1);
        chk("fill_idle_done_addr", 32'(done_addr), 20);

        // same fill with CPU streaming to 0x3F; start coincides with a CPU handshake
        clear_logs();
        cpu_valid = 1; cpu_address = 16'h3F; cpu_value = 24'h111111; cpu_mask = 24'h0F0F0F;
        start_fill(2, 4, 1, 2);
        repeat (11) cyc();
        cpu_valid = 0;
        repeat (3) cyc();
        exp_q = {16'h3F, 16'd10, 16'h3F, 16'd11, 16'h3F, 16'd12, 16'h3F,
                 16'd18, 16'h3F, 16'd19, 16'h3F, 16'd20};
        check_log("fill_cpu", exp_q, 0);
        chk("fill_cpu_done_addr", 32'(done_addr), 20);
        chk("fill_cpu_done_cnt", 32'(done_cnt), 1);

        // rejected commands
        clear_logs();
        start_fill(5, 3, 0, 0);
        repeat (2) cyc();
        start_fill(0, 1, 0, 4);
        repeat (3) cyc();
        chk("err_cnt", 32'(err_cnt), 2);
        chk("err_writes", 32'(dut_log.size()), 0);
        chk("err_busy", 32'(busy_seen), 0);

        // full-screen fill, restart mid-fill ignored, reset after 10th write
        clear_logs();
        start_fill(0, 7, 0, 3);
        repeat (3) cyc();
        fill_x0 = 0; fill_x1 = 1; fill_y0 = 0; fill_y1 = 1;
        fill_start = 1;
        cyc();
        fill_start = 0;
        repeat (6) cyc();
        #4;
        reset = 0;
        #1;
        chk("abort_write", 32'(video_write), 0);
        chk("abort_busy", 32'(fill_busy), 0);
        repeat (2) cyc();
        reset = 1;
        repeat (3) cyc();
        exp_q = {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        check_log("abort", exp_q, 1);
        chk("abort_done", 32'(done_cnt), 0);
        cpu_valid = 1; cpu_address = 16'd7; cpu_value = 24'h00AA55; cpu_mask = 24'h00FFFF;
        cyc();
        cpu_valid = 0;
        repeat (2) cyc();
        chk("post_abort_cpu_len", 32'(dut_log.size()), 11);
        chk("post_abort_cpu_addr", 32'(dut_log[dut_log.size()-1]), 7);
        chk("post_abort_cpu_val", 32'(last_val), 32'h00AA55);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            cpu_valid   = ($urandom_range(0, 3) != 0);
            cpu_address = 16'($urandom);
            cpu_value   = 24'($urandom);
            cpu_mask    = 24'($urandom);
            fill_start  = ($urandom_range(0, 19) == 0);
            fill_x0     = 7'($urandom_range(0, 8));
            fill_x1     = 7'($urandom_range(0, 9));
            fill_y0     = 5'($urandom_range(0, 4));
            fill_y1     = 5'($urandom_range(0, 4));
            fill_value  = 24'($urandom);
            fill_mask   = 24'($urandom);
            reset       = ($urandom_range(0, 499) != 0);
            cyc();
        end
        reset = 1; cpu_valid = 0; fill_start = 0;
        repeat (40) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_write_scheduler.md
# video_write_scheduler

Write-side controller for the text-mode video memory. It shares the single masked-write port (`video_write`/`video_address`/`video_value`/`video_mask`) between two requesters: a CPU single-cell write stream and an internal rectangle-fill engine used for clears, window fills and attribute painting. It sits between the host/command logic and `video_memory`, and issues at most one masked write per `clk` cycle.

## Interface
- `COLS`, default `` `TEXTCOLS_CHAR ``: characters per row; row stride for address generation.
- `ROWS`, default `` `TEXTROWS_CHAR ``: character rows; `COLS*ROWS` ≤ 65536.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 = reset.
- `cpu_valid`  in  1  CPU write request.
- `cpu_ready`  out  1  CPU request accepted this edge when high together with `cpu_valid`.
- `cpu_address`  in  16  linear cell address.
- `cpu_value`  in  `` `CHARATTR_RANGE ``  write data.
- `cpu_mask`  in  `` `CHARATTR_RANGE ``  bit mask; 1 = bit written.
- `fill_start`  in  1  single-cycle fill command strobe.
- `fill_x0`, `fill_x1`  in  `` `TEXTCOLS_RANGE ``  inclusive column bounds.
- `fill_y0`, `fill_y1`  in  `` `TEXTROWS_RANGE ``  inclusive row bounds.
- `fill_value`, `fill_mask`  in  `` `CHARATTR_RANGE ``  data and mask applied to every cell.
- `fill_busy`  out  1  fill in progress.
- `fill_done`  out  1  one-cycle pulse on the last fill write.
- `fill_error`  out  1  one-cycle pulse when a command is rejected.
- `video_write`, `video_address` (16), `video_value`, `video_mask`  out  registered write port to video memory.

## Operation
- States: IDLE, FILL. Reset → IDLE. All outputs 0 during and after reset; `cpu_ready` is 1 after reset.
- IDLE: `cpu_ready`=1. When `fill_start`=1, the command is validated on that edge.
- Validation: the command is rejected if x0>x1, y0>y1, x1≥COLS or y1≥ROWS. A rejected command pulses `fill_error`, stays in IDLE and produces no writes.
- Accepted fill: x0, x1, y0 and y1 are latched along with the value and mask. Set x=x0, y=y0, row_base=y0*COLS, `fill_busy`=1, and go to FILL.
  - row_base is computed without a multiplier. It can be built by repeated addition before the first grant, or by a shift/add sequence.
  - The first fill write must issue no later than the second edge after the command is accepted.
- Fill address = row_base + x, truncated to 16 bits. Cells are written in raster order: x increments; when x=x1, x←x0, y++, row_base += COLS.
- `fill_start` during FILL is ignored; there is no error and no effect.
- Arbitration in FILL uses a `last_fill` bit, cleared on entry to FILL.
  - Grant CPU if `cpu_valid` and `last_fill`=1. Otherwise grant fill.
  - `cpu_ready` = !fill_busy | last_fill.
  - `last_fill` is set on each fill grant and cleared on each CPU grant.
  - With the CPU continuously valid, grants strictly alternate, starting with fill. With the CPU idle, fill writes every cycle.
- CPU writes pass through unchanged; the address is not range-checked.
- Last fill cell (x1, y1) granted: the write issues, `fill_done` pulses in the same cycle, `fill_busy` falls in the same cycle, and the state returns to IDLE.
- Reset mid-fill: immediate abort. No further writes, no `fill_done`.

## Timing
- CPU: a handshake at edge N puts `video_write`=1 with that address, value and mask in the cycle after N. Latency is 1 cycle. Back-to-back transfers are allowed every cycle in IDLE.
- Fill: `fill_start` sampled at edge N → `fill_busy`=1 after N. Fill writes begin at the latest after edge N+2.
- `fill_error` is high for exactly one cycle, after edge N.
- `video_write`=0 in any cycle without a grant. `video_address`, `video_value` and `video_mask` hold their previous values when idle.
- A `fill_start` coinciding with a CPU handshake in IDLE: the CPU write completes, and the fill is accepted on the same edge.

## Test plan
- Bench parameters COLS=8, ROWS=4.
- Reset, then a CPU write with address 5, value 0x123456 and mask 0xFFFFFF → one cycle with `video_write`=1, `video_address`=5, value 0x123456 and mask 0xFFFFFF. All outputs are 0 during reset.
- Fill (2,1)–(4,2) with the CPU idle → six consecutive writes to addresses 10,11,12,18,19,20. `fill_done` pulses with address 20, `fill_busy` falls, and no seventh write occurs.
- Same fill with `cpu_valid` held high at address 0x3F → writes alternate F,C,F,C… (10, 3F, 11, 3F, …, 20). `cpu_ready` toggles with them, and the fill takes 11 write cycles.
- Fill with x0=5, x1=3, then a separate fill with y1=4 → each pulses `fill_error` for one cycle. No writes occur and `fill_busy` stays 0.
- Fill (0,0)–(7,3), with `fill_start` re-asserted mid-fill and `reset` asserted low after the 10th write → the second start is ignored. Outputs clear immediately, no `fill_done` pulses, and a later CPU write works normally.
